imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter N, default 24, the width of the encoded immediate field (instruction bits [N-1:0]).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, encode request, sampled only in IDLE.
REQ-005 SHALL have port value, input, 32, the 32-bit operand to encode, captured at the start edge.
REQ-006 SHALL have port ExtImm, input, 2, immediate class (00 rotated 8-bit, 01 unsigned 12-bit, 1x signed 24-bit word offset), captured at the start edge.
REQ-007 SHALL have port field, output, N, registered encoded immediate.
REQ-008 SHALL have port ok, output, 1, registered flag: value is encodable in the requested class.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a valid field/ok.
REQ-010 SHALL have port busy, output, 1, high from the cycle after the start edge until the cycle done pulses.

Function
REQ-011 SHALL implement FSM IDLE -> SEARCH -> DONE -> IDLE; busy = (state == SEARCH).
REQ-012 In IDLE with start=1 SHALL capture value and ExtImm, clear the rotation counter r to 0, and enter SEARCH.
REQ-013 SHALL ignore start while in SEARCH or DONE; captured operands are not disturbed.
REQ-014 ExtImm=00: each SEARCH cycle tests r; t = value rotated left by 2r; match when t[31:8]==0.
REQ-015 ExtImm=00 match: field = {zero pad, r[3:0], t[7:0]} (bits [11:8]=r, [7:0]=imm8), ok=1, go to DONE; smallest matching r wins.
REQ-016 ExtImm=00, no match at r=15: field=0, ok=0, go to DONE; otherwise r increments by 1 per cycle.
REQ-017 ExtImm=01: single SEARCH cycle; value<4096 -> field={zero pad, value[11:0]}, ok=1; else field=0, ok=0.
REQ-018 ExtImm=1x: single SEARCH cycle; ok=1 iff value[1:0]==0 and value[31:25] all equal value[25]; then field=value[25:2], else field=0, ok=0.
REQ-019 Latency: with start edge E0 and match at rotation k (k=0 for 01/1x, k=15 for 00 failure), field/ok update and done=1 in the cycle after edge E0+1+k.
REQ-020 done SHALL be high exactly one cycle (DONE state); DONE returns to IDLE unconditionally.
REQ-021 field and ok SHALL hold their last result from DONE until the next result is written.
REQ-022 start sampled high in the IDLE cycle immediately after DONE SHALL begin a new encode (back-to-back allowed).
REQ-023 Round-trip: whenever ok=1, decoding field under the same ExtImm by the codebase's immediate extender (with rotation applied for class 00) SHALL reproduce value exactly.

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, r=0, field=0, ok=0, done=0, busy=0, independent of clk.
REQ-025 Reset during SEARCH SHALL abort the operation; no done pulse for the aborted request.
REQ-026 First start SHALL be honoured on the first rising edge with reset_n high.

Verification
REQ-027 ExtImm=00, value=0x000000FF -> done at E0+1, field=0x0000FF, ok=1; value=0xC000003F -> done at E0+2, field=0x0001FF.
REQ-028 ExtImm=00, value=0xFF000000 -> r=4, done at E0+5, field=0x0004FF, ok=1; value=0x00000101 -> done at E0+16, field=0, ok=0.
REQ-029 ExtImm=01, value=0x00000FFF -> field=0x000FFF, ok=1; value=0x00001000 -> field=0, ok=0; both done at E0+1.
REQ-030 ExtImm=10, value=0xFFFFFFF8 -> field=0xFFFFFE, ok=1; value=0x00000006 -> ok=0; value=0x02000000 -> ok=0.
REQ-031 start held high during a 16-cycle failing search -> only one done, next encode begins the IDLE cycle after done; start on that cycle accepted.
REQ-032 reset_n pulsed low at r=3 of a class-00 search -> busy/done/ok/field at 0 immediately, no done, fresh start after release encodes normally.

Source files
------------

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - encodes a 32-bit operand into a rotated-8, unsigned-12 or signed word-offset immediate field
module imm_encoder #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [31:0]  value,
    input  logic [1:0]   ExtImm,
    output logic [N-1:0] field,
    output logic         ok,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t       state;
    state_t       nextState;
    logic [31:0]  valueQ;
    logic [1:0]   extQ;
    logic [3:0]   rot;
    logic [4:0]   rotAmt;
    logic [31:0]  rotated;
    logic         lastTry;
    logic         resultOk;
    logic [N-1:0] resultField;

    // Rotating left by 2r undoes the decoder's rotate-right, so t[7:0] is the imm8 candidate.
    assign rotAmt  = {rot, 1'b0};
    assign rotated = (valueQ << rotAmt) | (valueQ >> (6'd32 - {1'b0, rotAmt}));

    always_comb begin
        resultField = '0;
        resultOk    = 1'b0;
        lastTry     = 1'b1;
        case (extQ)
            2'b00: begin
                lastTry = (rot == 4'hF);
                if (rotated[31:8] == 24'd0) begin
                    resultField = N'({rot, rotated[7:0]});
                    resultOk    = 1'b1;
                    lastTry     = 1'b1;
                end
            end
            2'b01: begin
                if (valueQ[31:12] == 20'd0) begin
                    resultField = N'(valueQ[11:0]);
                    resultOk    = 1'b1;
                end
            end
            default: begin
                // Word offset must be aligned and fit a sign-extended 26-bit byte offset.
                if ((valueQ[1:0] == 2'b00) && (valueQ[31:25] == {7{valueQ[25]}})) begin
                    resultField = N'(valueQ[25:2]);
                    resultOk    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SEARCH;
            SEARCH:  if (lastTry) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valueQ <= '0;
            extQ   <= '0;
            rot    <= '0;
            field  <= '0;
            ok     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        valueQ <= value;
                        extQ   <= ExtImm;
                        rot    <= '0;
                    end
                end
                SEARCH: begin
                    if (lastTry) begin
                        field <= resultField;
                        ok    <= resultOk;
                    end else begin
                        rot <= rot + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state == SEARCH);

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed vector bench for imm_encoder
module tb_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] value;
    logic [1:0]  ExtImm;
    logic [23:0] field;
    logic        ok;
    logic        done;
    logic        busy;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  ext;
        logic [23:0] expField;
        logic        expOk;
        int          expLat;
    } vec_t;

    vec_t vecs[15];

    imm_encoder #(.N(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .value   (value),
        .ExtImm  (ExtImm),
        .field   (field),
        .ok      (ok),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] decode(input logic [1:0] ext, input logic [23:0] f);
        logic [31:0] imm;
        logic [4:0]  sh;
        if (ext == 2'b00) begin
            imm = {24'd0, f[7:0]};
            sh  = {f[11:8], 1'b0};
            return (imm >> sh) | (imm << (6'd32 - {1'b0, sh}));
        end else if (ext == 2'b01) begin
            return {20'd0, f[11:0]};
        end
        return {{6{f[23]}}, f, 2'b00};
    endfunction

    // Drives one request from an IDLE cycle and returns in the IDLE cycle after done.
    task automatic runVec(input logic [31:0] v, input logic [1:0] e, input logic [23:0] ef,
                          input logic eo, input int lat, input string nm);
        int cycles;
        value  = v;
        ExtImm = e;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, " busy"}, {31'd0, busy}, 32'd1);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (done) break;
        end
        check({nm, " latency"}, cycles, lat);
        check({nm, " field"}, {8'd0, field}, {8'd0, ef});
        check({nm, " ok"}, {31'd0, ok}, {31'd0, eo});
        if (eo && ok) check({nm, " roundtrip"}, decode(e, field), v);
        @(posedge clk); #1;
    endtask

    initial begin
        int dones;
        checks  = 0;
        errors  = 0;
        start   = 1'b0;
        value   = '0;
        ExtImm  = '0;
        reset_n = 1'b0;

        vecs[0]  = '{32'h000000FF, 2'b00, 24'h0000FF, 1'b1, 1};
        vecs[1]  = '{32'hC000003F, 2'b00, 24'h0001FF, 1'b1, 2};
        vecs[2]  = '{32'hFF000000, 2'b00, 24'h0004FF, 1'b1, 5};
        vecs[3]  = '{32'h00000101, 2'b00, 24'h000000, 1'b0, 16};
        vecs[4]  = '{32'h00000000, 2'b00, 24'h000000, 1'b1, 1};
        vecs[5]  = '{32'h000003FC, 2'b00, 24'h000FFF, 1'b1, 16};
        vecs[6]  = '{32'h80000001, 2'b00, 24'h000106, 1'b1, 2};
        vecs[7]  = '{32'h00000FFF, 2'b01, 24'h000FFF, 1'b1, 1};
        vecs[8]  = '{32'h00001000, 2'b01, 24'h000000, 1'b0, 1};
        vecs[9]  = '{32'h00000000, 2'b01, 24'h000000, 1'b1, 1};
        vecs[10] = '{32'hFFFFFFF8, 2'b10, 24'hFFFFFE, 1'b1, 1};
        vecs[11] = '{32'h00000006, 2'b10, 24'h000000, 1'b0, 1};
        vecs[12] = '{32'h02000000, 2'b10, 24'h000000, 1'b0, 1};
        vecs[13] = '{32'h01FFFFFC, 2'b11, 24'h7FFFFF, 1'b1, 1};
        vecs[14] = '{32'hFE000000, 2'b11, 24'h800000, 1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset ok", {31'd0, ok}, 32'd0);
        check("reset field", {8'd0, field}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            runVec(vecs[i].value, vecs[i].ext, vecs[i].expField, vecs[i].expOk,
                   vecs[i].expLat, $sformatf("vec%0d", i));
        end

        // Result holds across idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("hold field", {8'd0, field}, 32'h00800000);
        check("hold ok", {31'd0, ok}, 32'd1);

        // Start held high through a failing search; operand changes must not leak in.
        value  = 32'h00000101;
        ExtImm = 2'b00;
        start  = 1'b1;
        @(posedge clk); #1;
        value = 32'h000000FF;
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("held done now", {31'd0, done}, 32'd1);
        check("held field", {8'd0, field}, 32'd0);
        check("held ok", {31'd0, ok}, 32'd0);
        @(posedge clk); #1;
        if (done) dones++;
        check("held idle busy", {31'd0, busy}, 32'd0);
        check("held done count", dones, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accepted", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("b2b done", {31'd0, done}, 32'd1);
        check("b2b field", {8'd0, field}, 32'h000000FF);
        check("b2b ok", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid-search at r=3.
        value  = 32'h00000101;
        ExtImm = 2'b00;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort ok", {31'd0, ok}, 32'd0);
        check("abort field", {8'd0, field}, 32'd0);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (c == 2) reset_n = 1'b1;
        end
        check("abort no done", dones, 0);
        runVec(32'hC000003F, 2'b00, 24'h0001FF, 1'b1, 2, "post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
